bsg_credit_to_token_gen: RTL and testbench

BSG_CREDIT_TO_TOKEN_GEN -- requirements
Module: bsg_credit_to_token_gen

---
 rtl/bsg_credit_to_token_gen.sv | 87 ++++++++
 tb/tb_bsg_credit_to_token_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_credit_to_token_gen.sv
// Turns freed receiver credits into spaced single-cycle token pulses for a remote credit counter.
// Every 2^lg credits earn one token; earned tokens queue (saturating) until downstream is ready.
module bsg_credit_to_token_gen #(
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int max_tokens_p                    = 4,
  parameter int token_gap_p                     = 1,
  localparam int pending_w_lp = $clog2(max_tokens_p + 1),
  localparam int gap_w_lp     = $clog2(token_gap_p + 1),
  localparam int acc_w_lp     = (lg_credit_to_token_decimation_p > 0)
                                ? lg_credit_to_token_decimation_p : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    credit_i,
  input  logic                    ready_i,
  output logic                    token_o,
  output logic [pending_w_lp-1:0] pending_tokens_o,
  output logic                    overflow_o
);

  localparam logic [pending_w_lp-1:0] max_tokens_lp = pending_w_lp'(max_tokens_p);
  localparam logic [gap_w_lp-1:0]     gap_load_lp   = gap_w_lp'(token_gap_p);

  logic [acc_w_lp-1:0]     acc_q, acc_d;
  logic [pending_w_lp-1:0] pending_q, pending_d;
  logic [gap_w_lp-1:0]     gap_q, gap_d;
  logic                    token_q, token_d;
  logic                    overflow_q, overflow_d;
  logic                    earned, issue;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q      <= '0;
      pending_q  <= '0;
      gap_q      <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      gap_q      <= gap_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    acc_d      = acc_q;
    pending_d  = pending_q;
    gap_d      = gap_q;
    overflow_d = overflow_q;
    earned     = 1'b0;

    // With no decimation the accumulator is a constant zero and every credit earns.
    if (lg_credit_to_token_decimation_p == 0) begin
      earned = credit_i;
    end else begin
      earned = credit_i & (&acc_q);
      acc_d  = acc_q + acc_w_lp'(credit_i);
    end

    // Issue only from registered state; the ~token_q term keeps each pulse one cycle wide.
    issue   = ready_i & (pending_q != '0) & (gap_q == '0) & ~token_q;
    token_d = issue;

    if (issue) begin
      gap_d = gap_load_lp;
    end else if (gap_q != '0) begin
      gap_d = gap_q - gap_w_lp'(1);
    end

    if (earned && !issue) begin
      if (pending_q == max_tokens_lp) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + pending_w_lp'(1);
      end
    end else if (issue && !earned) begin
      pending_d = pending_q - pending_w_lp'(1);
    end
  end

  assign token_o          = token_q;
  assign pending_tokens_o = pending_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_bsg_credit_to_token_gen.sv
// Directed bench: stimulus pushes expected token edge cycles, a monitor pops them as pulses appear.
// u_dut runs lg=2/max=4/gap=2; u_dut0 runs lg=0/max=4/gap=1.
module tb_bsg_credit_to_token_gen;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b1;
  logic       credit_i = 1'b0, ready_i = 1'b0;
  logic       credit0_i = 1'b0, ready0_i = 1'b0;
  logic       token_o, overflow_o, token0_o, overflow0_o;
  logic [2:0] pending_tokens_o, pending0_o;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int exp_q[$];
  int exp0_q[$];
  int t0;
  logic tok_prev = 1'b0, tok0_prev = 1'b0;

  bsg_credit_to_token_gen #(
    .lg_credit_to_token_decimation_p(2), .max_tokens_p(4), .token_gap_p(2)
  ) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .credit_i(credit_i), .ready_i(ready_i),
    .token_o(token_o), .pending_tokens_o(pending_tokens_o), .overflow_o(overflow_o)
  );

  bsg_credit_to_token_gen #(
    .lg_credit_to_token_decimation_p(0), .max_tokens_p(4), .token_gap_p(1)
  ) u_dut0 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .credit_i(credit0_i), .ready_i(ready0_i),
    .token_o(token0_o), .pending_tokens_o(pending0_o), .overflow_o(overflow0_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input logic c, input logic r);
    credit_i = c;
    ready_i  = r;
    @(posedge clk_i);
    #1;
  endtask

  task automatic step0(input logic c, input logic r);
    credit0_i = c;
    ready0_i  = r;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (token_o) begin
      if (exp_q.size() == 0) chk("unexpected_token", cyc, -1);
      else chk("token_edge", cyc, exp_q.pop_front());
      chk("token_width", int'(tok_prev), 0);
    end
    tok_prev = token_o;
  end

  always @(negedge clk_i) begin
    if (token0_o) begin
      if (exp0_q.size() == 0) chk("unexpected_token0", cyc, -1);
      else chk("token0_edge", cyc, exp0_q.pop_front());
      chk("token0_width", int'(tok0_prev), 0);
    end
    tok0_prev = token0_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset_n_i = 1'b0;
    #2;
    chk("reset_token", int'(token_o), 0);
    chk("reset_pending", int'(pending_tokens_o), 0);
    chk("reset_overflow", int'(overflow_o), 0);
    chk("reset_pending0", int'(pending0_o), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    repeat (2) step(1'b0, 1'b1);

    // four credits earn one token, issued on the following edge
    t0 = cyc;
    exp_q.push_back(t0 + 5);
    repeat (4) step(1'b1, 1'b1);
    chk("one_tok_pending", int'(pending_tokens_o), 1);
    step(1'b0, 1'b1);
    chk("one_tok_token", int'(token_o), 1);
    chk("one_tok_drained", int'(pending_tokens_o), 0);
    repeat (4) step(1'b0, 1'b1);

    // twelve credits: three pulses, spaced by the credit rate (4 cycles)
    t0 = cyc;
    exp_q.push_back(t0 + 5);
    exp_q.push_back(t0 + 9);
    exp_q.push_back(t0 + 13);
    repeat (12) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("twelve_pending", int'(pending_tokens_o), 0);
    chk("twelve_overflow", int'(overflow_o), 0);

    // saturation with ready low, then back-to-back drain at period gap+1
    repeat (16) step(1'b1, 1'b0);
    chk("sat16_pending", int'(pending_tokens_o), 4);
    chk("sat16_overflow", int'(overflow_o), 0);
    repeat (4) step(1'b1, 1'b0);
    chk("sat20_pending", int'(pending_tokens_o), 4);
    chk("sat20_overflow", int'(overflow_o), 1);
    t0 = cyc;
    exp_q.push_back(t0 + 1);
    exp_q.push_back(t0 + 4);
    exp_q.push_back(t0 + 7);
    exp_q.push_back(t0 + 10);
    repeat (12) step(1'b0, 1'b1);
    chk("drain_pending", int'(pending_tokens_o), 0);
    chk("drain_overflow_sticky", int'(overflow_o), 1);

    // token earned on the issue cycle leaves pending unchanged
    repeat (7) step(1'b1, 1'b0);
    chk("earn_issue_pre", int'(pending_tokens_o), 1);
    t0 = cyc;
    exp_q.push_back(t0 + 1);
    exp_q.push_back(t0 + 4);
    step(1'b1, 1'b1);
    chk("earn_issue_pending", int'(pending_tokens_o), 1);
    chk("earn_issue_token", int'(token_o), 1);
    repeat (5) step(1'b0, 1'b1);
    chk("earn_issue_drained", int'(pending_tokens_o), 0);

    // reset discards a partial accumulation
    repeat (3) step(1'b1, 1'b0);
    reset_n_i = 1'b0;
    #1;
    chk("rst_overflow_clr", int'(overflow_o), 0);
    chk("rst_pending_clr", int'(pending_tokens_o), 0);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    step(1'b1, 1'b0);
    chk("rst_acc_one", int'(pending_tokens_o), 0);
    repeat (2) step(1'b1, 1'b0);
    chk("rst_acc_three", int'(pending_tokens_o), 0);
    step(1'b1, 1'b0);
    chk("rst_acc_four", int'(pending_tokens_o), 1);

    // reset asserted mid-pulse clears token_o without a clock edge
    step(1'b0, 1'b1);
    chk("midpulse_high", int'(token_o), 1);
    reset_n_i = 1'b0;
    #1;
    chk("midpulse_token_clr", int'(token_o), 0);
    chk("midpulse_pending_clr", int'(pending_tokens_o), 0);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    repeat (6) step(1'b0, 1'b1);
    chk("post_rst_pending", int'(pending_tokens_o), 0);

    // no decimation, gap 1: alternating pulses, pending peaks at 3
    t0 = cyc;
    for (int k = 1; k <= 6; k++) exp0_q.push_back(t0 + 2 * k);
    step0(1'b1, 1'b1);
    chk("lg0_pending_e1", int'(pending0_o), 1);
    step0(1'b1, 1'b1);
    step0(1'b1, 1'b1);
    chk("lg0_pending_e3", int'(pending0_o), 2);
    step0(1'b1, 1'b1);
    step0(1'b1, 1'b1);
    chk("lg0_pending_e5", int'(pending0_o), 3);
    step0(1'b1, 1'b1);
    chk("lg0_pending_e6", int'(pending0_o), 3);
    repeat (8) step0(1'b0, 1'b1);
    chk("lg0_drained", int'(pending0_o), 0);
    chk("lg0_overflow", int'(overflow0_o), 0);

    chk("missing_tokens", exp_q.size(), 0);
    chk("missing_tokens0", exp0_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
